vdp_host_port: RTL and testbench

VDP_HOST_PORT -- requirements
Module: vdp_host_port

---
 rtl/vdp_host_port.sv | 173 +++++++++++++++++
 tb/tb_vdp_host_port.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_host_port.sv
// CPU host port of a video display processor.
// Accepts CPU accesses on a data port and a control port, turns control-port
// byte pairs into VRAM address loads or VDP register writes, and performs the
// resulting VRAM reads/writes in display-granted free slots. Data reads are
// served from a read-ahead buffer that is refilled after every read.
//
// Address loading: the second control byte supplies the upper address bits,
// i.e. addr = {byte, lowByte} truncated to RamBits. Bits [7:6] of that byte
// are the command code, so for RamBits up to 14 the address field is clean;
// RamBits must lie in 9..16.
module vdp_host_port #(
  parameter int RamBits = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpuStb,
  input  logic               cpuWr,
  input  logic               cpuPort,
  input  logic [7:0]         cpuDataIn,
  output logic [7:0]         cpuDataOut,
  output logic               cpuWait,
  output logic               ramReq,
  input  logic               ramGrant,
  output logic               ramWe,
  output logic [RamBits-1:0] ramAddr,
  output logic [7:0]         ramDataOut,
  input  logic [7:0]         ramDataIn,
  output logic               regWe,
  output logic [2:0]         regIdx,
  output logic [7:0]         regData
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PEND = 2'd1,
    RD_PEND = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  localparam logic [RamBits-1:0] AddrOne = RamBits'(1);

  state_t             state;
  state_t             next_state;
  logic               phase;
  logic [7:0]         lowByte;
  logic [7:0]         wrBuf;
  logic [7:0]         rdBuf;
  logic [RamBits-1:0] addr;
  logic [RamBits-1:0] newAddr;

  logic       busy;
  logic       noStall;
  logic       accept;
  logic       accDataWr;
  logic       accDataRd;
  logic       accCtrlRd;
  logic       accCtrlLo;
  logic       accCtrlHi;
  logic [1:0] code;
  logic       addrStep;

  // Access decode: phase-0 control writes and control reads never stall,
  // everything else waits for the in-flight VRAM access to finish.
  assign busy      = (state != IDLE);
  assign noStall   = cpuPort & (~cpuWr | ~phase);
  assign cpuWait   = busy & cpuStb & ~noStall;
  assign accept    = cpuStb & ~cpuWait;
  assign accDataWr = accept & ~cpuPort &  cpuWr;
  assign accDataRd = accept & ~cpuPort & ~cpuWr;
  assign accCtrlRd = accept &  cpuPort & ~cpuWr;
  assign accCtrlLo = accept &  cpuPort &  cpuWr & ~phase;
  assign accCtrlHi = accept &  cpuPort &  cpuWr &  phase;
  assign code      = cpuDataIn[7:6];
  assign newAddr   = RamBits'({cpuDataIn, lowByte});

  // Address advances after a granted write or once read data is captured.
  assign addrStep  = ((state == WR_PEND) & ramGrant) | (state == RD_DATA);

  assign ramAddr    = addr;
  assign ramDataOut = wrBuf;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and VRAM request decode.
  // NOTE: every output of this block gets a default first; otherwise a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    next_state = state;
    ramReq     = 1'b0;
    ramWe      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accDataWr)                         next_state = WR_PEND;
        else if (accDataRd)                    next_state = RD_PEND;
        else if (accCtrlHi && (code == 2'b00)) next_state = RD_PEND;
      end
      WR_PEND: begin
        ramReq = 1'b1;
        ramWe  = 1'b1;
        if (ramGrant) next_state = IDLE;
      end
      RD_PEND: begin
        ramReq = 1'b1;
        if (ramGrant) next_state = RD_DATA;
      end
      RD_DATA: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: control-port latching, buffers, address counter, register strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= 1'b0;
      lowByte    <= 8'h00;
      wrBuf      <= 8'h00;
      rdBuf      <= 8'h00;
      addr       <= '0;
      cpuDataOut <= 8'h00;
      regWe      <= 1'b0;
      regIdx     <= 3'd0;
      regData    <= 8'h00;
    end else begin
      regWe <= 1'b0;

      // Address loads are only accepted in IDLE, increments only happen
      // outside IDLE, so the two never collide.
      if (addrStep) addr <= addr + AddrOne;

      if (state == RD_DATA) rdBuf <= ramDataIn;

      if (accDataWr) begin
        wrBuf <= cpuDataIn;
        phase <= 1'b0;
      end

      if (accDataRd) begin
        cpuDataOut <= rdBuf;
        phase      <= 1'b0;
      end

      if (accCtrlRd) begin
        cpuDataOut <= {busy, phase, 6'b0};
        phase      <= 1'b0;
      end

      if (accCtrlLo) begin
        lowByte <= cpuDataIn;
        phase   <= 1'b1;
      end

      if (accCtrlHi) begin
        phase <= 1'b0;
        unique case (code)
          2'b00, 2'b01: addr <= newAddr;
          2'b10: begin
            regWe   <= 1'b1;
            regIdx  <= cpuDataIn[2:0];
            regData <= lowByte;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vdp_host_port.sv
// Self-checking bench for vdp_host_port.
// Stimulus pushes expected VRAM writes, register writes and CPU read data into
// queues; a monitor on the falling edge pops and compares whenever the DUT
// performs a granted write, pulses regWe, or returns read data.
// RamBits = 14 so that a control byte pair can reach the top address (0x3FFF)
// and exercise the wrap to 0.
module tb_vdp_host_port;

  localparam int RB = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpuStb;
  logic          cpuWr;
  logic          cpuPort;
  logic [7:0]    cpuDataIn;
  logic [7:0]    cpuDataOut;
  logic          cpuWait;
  logic          ramReq;
  logic          ramGrant;
  logic          ramWe;
  logic [RB-1:0] ramAddr;
  logic [7:0]    ramDataOut;
  logic [7:0]    ramDataIn;
  logic          regWe;
  logic [2:0]    regIdx;
  logic [7:0]    regData;

  vdp_host_port #(.RamBits(RB)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpuStb     (cpuStb),
    .cpuWr      (cpuWr),
    .cpuPort    (cpuPort),
    .cpuDataIn  (cpuDataIn),
    .cpuDataOut (cpuDataOut),
    .cpuWait    (cpuWait),
    .ramReq     (ramReq),
    .ramGrant   (ramGrant),
    .ramWe      (ramWe),
    .ramAddr    (ramAddr),
    .ramDataOut (ramDataOut),
    .ramDataIn  (ramDataIn),
    .regWe      (regWe),
    .regIdx     (regIdx),
    .regData    (regData)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] wr_q[$];   // {addr16, data8}
  logic [10:0] reg_q[$];  // {idx3, data8}
  logic [7:0]  rd_q[$];   // cpuDataOut after an accepted read

  logic          mem_load = 1'b1;
  logic [7:0]    mem [0:(1<<RB)-1];
  logic          rd_pending = 1'b0;
  logic [RB-1:0] last_rd_addr = '0;
  int            req_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: DUT event with no expected entry", name);
  endtask

  // VRAM model: writes at granted edges, read data one cycle after the grant.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < (1 << RB); i++) mem[i] <= 8'hA5;
      mem[14'h0100] <= 8'h11;
      mem[14'h0101] <= 8'h22;
    end else if (ramReq && ramGrant) begin
      if (ramWe) mem[ramAddr] <= ramDataOut;
      else       ramDataIn    <= mem[ramAddr];
    end
  end

  // Monitor: compares DUT activity against the expectation queues.
  always @(negedge clk) begin
    if (rd_pending) begin
      rd_pending = 1'b0;
      if (rd_q.size() == 0) unexpected("cpu_read");
      else check("cpu_read_data", 32'(cpuDataOut), 32'(rd_q.pop_front()));
    end
    if (!reset) begin
      if (cpuStb && !cpuWait && !cpuWr) rd_pending = 1'b1;
      if (ramReq) req_count++;
      if (ramReq && ramGrant && ramWe) begin
        if (wr_q.size() == 0) unexpected("vram_write");
        else check("vram_write", {8'h00, 16'(ramAddr), ramDataOut}, 32'(wr_q.pop_front()));
      end
      if (ramReq && ramGrant && !ramWe) last_rd_addr = ramAddr;
      if (regWe) begin
        if (reg_q.size() == 0) unexpected("reg_write");
        else check("reg_write", 32'({regIdx, regData}), 32'(reg_q.pop_front()));
      end
    end
  end

  // One CPU access; held while cpuWait is high, bounded.
  task automatic access(input logic port, input logic wr, input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1;
    cpuStb = 1'b1; cpuPort = port; cpuWr = wr; cpuDataIn = d;
    @(negedge clk);
    while (cpuWait && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (cpuWait) begin
      n_tests++;
      n_fail++;
      $display("FAIL access_timeout: cpuWait still 1, expected 0 within 200 cycles");
    end
    @(posedge clk); #1;
    cpuStb = 1'b0;
  endtask

  task automatic ctrl_wr(input logic [7:0] d); access(1'b1, 1'b1, d); endtask
  task automatic data_wr(input logic [7:0] d); access(1'b0, 1'b1, d); endtask
  task automatic ctrl_rd(input logic [7:0] exp); rd_q.push_back(exp); access(1'b1, 1'b0, 8'h00); endtask
  task automatic data_rd(input logic [7:0] exp); rd_q.push_back(exp); access(1'b0, 1'b0, 8'h00); endtask

  // Waits until no VRAM request is seen for two consecutive cycles.
  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < 500) begin
      @(negedge clk);
      n++;
      if (ramReq) quiet = 0;
      else        quiet++;
    end
    if (quiet < 2) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: ramReq still active, expected idle within 500 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpuDataOut"}, 32'(cpuDataOut), 32'h00);
    check({tag, "_cpuWait"},    32'(cpuWait),    32'h0);
    check({tag, "_ramReq"},     32'(ramReq),     32'h0);
    check({tag, "_ramWe"},      32'(ramWe),      32'h0);
    check({tag, "_regWe"},      32'(regWe),      32'h0);
    check({tag, "_regIdx"},     32'(regIdx),     32'h0);
    check({tag, "_regData"},    32'(regData),    32'h00);
    check({tag, "_ramAddr"},    32'(ramAddr),    32'h0);
    check({tag, "_ramDataOut"}, 32'(ramDataOut), 32'h00);
  endtask

  initial begin
    int stalls;
    int c0;
    reset = 1'b1; cpuStb = 1'b0; cpuWr = 1'b0; cpuPort = 1'b0;
    cpuDataIn = 8'h00; ramGrant = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    mem_load = 1'b0;
    reset    = 1'b0;

    // Address load then one write, grant always available.
    ctrl_wr(8'h34);
    ctrl_wr(8'h52);
    wr_q.push_back({16'h1234, 8'hAA});
    data_wr(8'hAA);
    wait_idle();
    check("addr_after_write", 32'(ramAddr), 32'h1235);

    // Register write: one regWe pulse, no VRAM traffic.
    c0 = req_count;
    reg_q.push_back({3'd5, 8'h07});
    ctrl_wr(8'h07);
    ctrl_wr(8'h85);
    repeat (4) @(negedge clk);
    check("regwrite_no_ramreq", 32'(req_count - c0), 32'd0);
    check("addr_kept_on_regwrite", 32'(ramAddr), 32'h1235);

    // Read-ahead from 0x0100 then two data reads.
    ctrl_wr(8'h00);
    ctrl_wr(8'h01);
    data_rd(8'h11);
    data_rd(8'h22);
    wait_idle();
    check("last_fetch_addr", 32'(last_rd_addr), 32'h0102);

    // Grant withheld: second write stalls until the first completes.
    ramGrant = 1'b0;
    ctrl_wr(8'h00);
    ctrl_wr(8'h42);
    wr_q.push_back({16'h0200, 8'h5A});
    wr_q.push_back({16'h0201, 8'hC3});
    data_wr(8'h5A);
    @(posedge clk); #1;
    cpuStb = 1'b1; cpuPort = 1'b0; cpuWr = 1'b1; cpuDataIn = 8'hC3;
    stalls = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpuWait) stalls++;
    end
    check("stall_cycles_no_grant", 32'(stalls), 32'd10);
    @(posedge clk); #1;
    ramGrant = 1'b1;
    c0 = 0;
    @(negedge clk);
    while (cpuWait && c0 < 50) begin
      c0++;
      @(negedge clk);
    end
    check("stall_released", 32'(cpuWait), 32'h0);
    @(posedge clk); #1;
    cpuStb = 1'b0;
    wait_idle();

    // Top of address space wraps to zero.
    ctrl_wr(8'hFF);
    ctrl_wr(8'h7F);
    wr_q.push_back({16'h3FFF, 8'h01});
    wr_q.push_back({16'h0000, 8'h02});
    data_wr(8'h01);
    data_wr(8'h02);
    wait_idle();
    check("addr_after_wrap", 32'(ramAddr), 32'h0001);

    // Control read after a single byte shows phase, then clears it.
    ctrl_wr(8'h99);
    ctrl_rd(8'h40);
    ctrl_wr(8'h10);
    ctrl_wr(8'h42);
    wr_q.push_back({16'h0210, 8'h77});
    data_wr(8'h77);
    wait_idle();

    // Write left pending, busy visible on status read, then reset mid-access.
    ramGrant = 1'b0;
    data_wr(8'hEE);
    ctrl_rd(8'h80);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 ramGrant = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("postrst");
    check("abandoned_write_mem", 32'(mem[14'h0211]), 32'hA5);
    check("written_0x0210", 32'(mem[14'h0210]), 32'h77);

    check("wr_q_drained",  32'(wr_q.size()),  32'd0);
    check("reg_q_drained", 32'(reg_q.size()), 32'd0);
    check("rd_q_drained",  32'(rd_q.size()),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
